// File: rtl/store_coalesce_buffer.sv
// Store coalescing buffer: in-order FIFO of word-aligned stores that merges same-word byte writes.
// Latency: accepted store is visible to chk_hit_o next cycle; issue on occupancy, flush or head idle timeout.
// Backpressure: st_ready_o low only when full and not merging; mem_valid_o held until mem_ready_i, gated by MAX_OUT.
// Ports: clk_i/rst_ni clock and async active-low reset; st_* store request; flush_i drain-until-empty;
//        mem_* issue handshake plus completion ack; chk_addr_i/chk_hit_o load hazard lookup; empty_o/full_o status.
module store_coalesce_buffer #(
   parameter int  DEPTH       = 4,
   parameter int  ADDR_W      = 64,
   parameter int  DATA_W      = 64,
   parameter int  COALESCE_EN = 1,
   parameter int  DRAIN_TH    = 2,
   parameter int  TIMEOUT     = 15,
   parameter int  MAX_OUT     = 7,
   localparam int BE_W        = DATA_W / 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              st_valid_i,
   output logic              st_ready_o,
   input  logic [ADDR_W-1:0] st_addr_i,
   input  logic [DATA_W-1:0] st_data_i,
   input  logic [BE_W-1:0]   st_be_i,
   input  logic              flush_i,
   output logic              mem_valid_o,
   input  logic              mem_ready_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   output logic [BE_W-1:0]   mem_be_o,
   input  logic              mem_ack_i,
   input  logic [ADDR_W-1:0] chk_addr_i,
   output logic              chk_hit_o,
   output logic              empty_o,
   output logic              full_o
);
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int IW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int OW  = $clog2(MAX_OUT + 1);
   localparam int OFF = $clog2(BE_W);
   localparam logic [ADDR_W-1:0] WMASK = ~((ADDR_W'(1) << OFF) - ADDR_W'(1));

   logic [DEPTH-1:0]  e_vld;
   logic [ADDR_W-1:0] e_addr [DEPTH];
   logic [DATA_W-1:0] e_data [DEPTH];
   logic [BE_W-1:0]   e_be   [DEPTH];

   logic [PW-1:0] head_q, tail_q;
   logic [CW-1:0] count_q;
   logic [OW-1:0] out_q;
   logic [IW-1:0] idle_q;
   logic          flush_q;
   logic          hold_q;      // issue presented last cycle and not taken

   logic [ADDR_W-1:0] st_waddr, chk_waddr;
   logic              merge_hit;
   logic [PW-1:0]     merge_idx;
   logic              push, push_alloc, pop, ack_eff, drain;

   assign st_waddr  = st_addr_i & WMASK;
   assign chk_waddr = chk_addr_i & WMASK;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0) && (out_q == '0);

   assign drain       = (count_q >= CW'(DRAIN_TH)) || flush_q || (idle_q == IW'(TIMEOUT));
   assign mem_valid_o = hold_q || ((count_q != '0) && drain && (out_q < OW'(MAX_OUT)));
   assign mem_addr_o  = e_addr[head_q];
   assign mem_data_o  = e_data[head_q];
   assign mem_be_o    = e_be[head_q];

   // Scan oldest to youngest so the last match wins. The head is frozen while
   // it is being offered to memory, so it cannot absorb new bytes then.
   always_comb begin
      merge_hit = 1'b0;
      merge_idx = '0;
      if (COALESCE_EN != 0) begin
         for (int i = 0; i < DEPTH; i++) begin
            automatic logic [PW-1:0] idx = head_q + PW'(i);
            if (e_vld[idx] && (e_addr[idx] == st_waddr) && !((idx == head_q) && mem_valid_o)) begin
               merge_hit = 1'b1;
               merge_idx = idx;
            end
         end
      end
   end

   always_comb begin
      chk_hit_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (e_vld[i] && (e_addr[i] == chk_waddr)) chk_hit_o = 1'b1;
      end
   end

   // Ready ignores a same-cycle pop so it never depends on mem_ready_i.
   assign st_ready_o = !full_o || merge_hit;
   assign push       = st_valid_i && st_ready_o;
   assign push_alloc = push && !merge_hit;
   assign pop        = mem_valid_o && mem_ready_i;
   assign ack_eff    = mem_ack_i && (out_q != '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         e_vld   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            e_addr[i] <= '0;
            e_data[i] <= '0;
            e_be[i]   <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         out_q   <= '0;
         idle_q  <= '0;
         flush_q <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         if (push && merge_hit) begin
            for (int b = 0; b < BE_W; b++) begin
               if (st_be_i[b]) e_data[merge_idx][b*8 +: 8] <= st_data_i[b*8 +: 8];
            end
            e_be[merge_idx] <= e_be[merge_idx] | st_be_i;
         end
         if (push_alloc) begin
            e_vld[tail_q]  <= 1'b1;
            e_addr[tail_q] <= st_waddr;
            e_data[tail_q] <= st_data_i;
            e_be[tail_q]   <= st_be_i;
            tail_q         <= tail_q + PW'(1);
         end
         if (pop) begin
            e_vld[head_q] <= 1'b0;
            head_q        <= head_q + PW'(1);
         end

         case ({push_alloc, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase

         case ({pop, ack_eff})
            2'b10:   out_q <= out_q + OW'(1);
            2'b01:   out_q <= out_q - OW'(1);
            default: out_q <= out_q;
         endcase

         if (push || pop)                                   idle_q <= '0;
         else if ((count_q != '0) && (idle_q != IW'(TIMEOUT))) idle_q <= idle_q + IW'(1);

         if (flush_i)              flush_q <= 1'b1;
         else if (count_q == '0)   flush_q <= 1'b0;

         hold_q <= mem_valid_o && !mem_ready_i;
      end
   end
endmodule

// File: doc/store_coalesce_buffer.md
STORE_COALESCE_BUFFER -- requirements
Module: store_coalesce_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 64, store address width.
REQ-003 SHALL have parameter DATA_W, default 64, word width; BE_W = DATA_W/8.
REQ-004 SHALL have parameter COALESCE_EN, default 1, enables merging into resident entries.
REQ-005 SHALL have parameter DRAIN_TH, default 2, occupancy at which draining starts (1..DEPTH).
REQ-006 SHALL have parameter TIMEOUT, default 15, idle cycles before a lone head is drained.
REQ-007 SHALL have parameter MAX_OUT, default 7, maximum issued-but-unacked stores.
REQ-008 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-009 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-010 SHALL have ports st_valid_i/st_ready_o, in/out, 1, store request handshake.
REQ-011 SHALL have ports st_addr_i (ADDR_W), st_data_i (DATA_W), st_be_i (BE_W), inputs, store payload.
REQ-012 SHALL have port flush_i, input, 1, forces draining until empty.
REQ-013 SHALL have ports mem_valid_o/mem_ready_i, out/in, 1, memory issue handshake.
REQ-014 SHALL have ports mem_addr_o (ADDR_W), mem_data_o (DATA_W), mem_be_o (BE_W), outputs, head entry payload.
REQ-015 SHALL have port mem_ack_i, input, 1, one pulse per completed store.
REQ-016 SHALL have port chk_addr_i (ADDR_W) input and chk_hit_o (1) output, load hazard check.
REQ-017 SHALL have ports empty_o (1) and full_o (1), outputs, status.

Function
REQ-018 Entries SHALL be FIFO-ordered; each holds word address (addr with low log2(BE_W) bits zeroed), data, byte-enables.
REQ-019 Push SHALL occur on st_valid_i && st_ready_o.
REQ-020 Merge hit: COALESCE_EN=1, valid entry with equal word address, entry not head while mem_valid_o=1; merged bytes SHALL overwrite where st_be_i set, be SHALL be OR-ed; no allocation.
REQ-021 Multiple matching entries: youngest SHALL be merged.
REQ-022 No merge hit: new entry SHALL be allocated at tail.
REQ-023 st_ready_o SHALL = !full_o || merge hit; SHALL NOT depend on same-cycle pop.
REQ-024 Drain condition: count >= DRAIN_TH, or flush pending, or head idle counter == TIMEOUT.
REQ-025 mem_valid_o SHALL assert when count>0, drain condition holds, outstanding < MAX_OUT.
REQ-026 Once asserted, mem_valid_o and payload SHALL hold until mem_ready_i, regardless of drain condition.
REQ-027 Head SHALL pop on mem_valid_o && mem_ready_i; outstanding counter +1.
REQ-028 mem_ack_i SHALL decrement outstanding; simultaneous issue and ack SHALL leave it unchanged; ack at zero SHALL be ignored.
REQ-029 Idle counter SHALL count cycles with count>0 and no push, saturate at TIMEOUT, clear on any push or pop.
REQ-030 flush_i pulse SHALL set a flush-pending flag, cleared when count==0.
REQ-031 chk_hit_o SHALL be combinational: 1 if any valid entry word address equals chk_addr_i word address.
REQ-032 empty_o SHALL = (count==0 && outstanding==0); full_o SHALL = (count==DEPTH).
REQ-033 Same-cycle push-allocate and pop SHALL keep count unchanged; full buffer with pop and non-merging push SHALL stall push (st_ready_o=0).
REQ-034 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-035 rst_ni low SHALL asynchronously clear all entries, pointers, count, outstanding, idle counter, flush flag.
REQ-036 During reset: st_ready_o=1, mem_valid_o=0, mem payload=0, chk_hit_o=0, empty_o=1, full_o=0.
REQ-037 Reset mid-handshake SHALL drop the store; no replay after release.

Verification
REQ-038 Two stores to 0x1000 (be 0x0F data 0x11.., be 0xF0 data 0x22..) -> one entry, be 0xFF, merged data, count 1.
REQ-039 Single store, no further traffic, mem_ready_i=1 -> mem_valid_o at idle count 15, pop next edge.
REQ-040 Fill DEPTH=4 with distinct addresses, mem_ready_i=0 -> full_o=1, st_ready_o=0 for new address, 1 for resident address.
REQ-041 7 issues with no acks -> mem_valid_o held 0 with entries pending; one ack -> issue resumes next cycle.
REQ-042 Store to head address while mem_valid_o=1, mem_ready_i=0 -> new entry allocated, head payload unchanged.
REQ-043 Assert rst_ni=0 with 3 entries and 2 outstanding -> empty_o=1 immediately, mem_valid_o=0.
